alu_seq_unit: RTL
=================

# alu_seq_unit

Parametrised, handshaked ALU execution unit that folds ALU control decoding and execution into one sequential block. It extends the R-type operation set with XOR, SLTU, SRL and SRA. Shifts run iteratively, one bit per cycle, so no barrel shifter is needed. It sits between the control unit (alu_op, funct3, funct7_5) and writeback in the multi-cycle datapath.

## Interface
- XLEN, 32: operand/result width; must be a power of two ≥ 8.
- SHW, $clog2(XLEN): shift-amount width; derived, do not override.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- alu_op  input  2  00 add, 01 sub, 10 R-type decode, 11 illegal.
- funct3  input  3  R-type function field.
- funct7_5  input  1  bit 30 of instruction.
- src_a  input  XLEN  operand A.
- src_b  input  XLEN  operand B; shift amount is src_b[SHW-1:0].
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  registered result.
- zero  output  1  result == 0, registered with result.
- illegal  output  1  the request decoded to no legal operation.

## Operation
- Accept: in_valid && in_ready at a rising edge. Inputs are sampled only then; they are don't-care otherwise.
- Decode of {funct7_5, funct3} when alu_op=10:
  - 0000 add; 1000 sub.
  - 0001 sll; 0101 srl; 1101 sra.
  - 0010 slt (signed); 0011 sltu.
  - 0100 xor; 0110 or; 0111 and.
  - Any other code is illegal.
- alu_op=00 is add and alu_op=01 is sub, regardless of funct fields. alu_op=11 is illegal.
- Arithmetic:
  - add/sub are modulo 2^XLEN; carry-out is discarded.
  - slt/sltu write 1 or 0 zero-extended to XLEN.
- State machine:
  - IDLE: in_ready=1.
    - Accept of a non-shift op (or a shift with amount 0): compute, register result/zero/illegal, go DONE.
    - Accept of a shift with amount k>0: result←src_a, cnt←k, latch shift type, go SHIFT.
  - SHIFT: each edge shifts result by one bit and decrements cnt.
    - sll inserts 0 at the LSB; srl inserts 0 at the MSB; sra replicates the MSB.
    - When cnt==1 at an edge, perform the final shift, update zero, and go DONE.
  - DONE: out_valid=1. On out_ready, go IDLE.
    - result/zero/illegal stay unchanged until the next accept.
- Illegal op: result=0, zero=1, illegal=1, same timing as a non-shift op.
- in_ready is low in SHIFT and DONE. There is no accept in the same cycle as an output handshake.
- Reset (at any time, including mid-SHIFT or in DONE with out_valid held):
  - Go immediately to IDLE and drop any in-flight op.
  - result=0, zero=1, illegal=0, out_valid=0, cnt=0, in_ready=1.

## Timing
- Accept at edge E0.
  - Non-shift, illegal, or shift-by-0: out_valid high from E0 until the out_ready edge.
  - Shift by k≥1: SHIFT occupies edges E1..Ek; out_valid high from Ek. Latency is k cycles beyond the non-shift case.
- Maximum shift latency is XLEN-1 extra cycles (k=31 for XLEN=32).
- Throughput for non-shift ops with out_ready tied high: one op per 2 cycles (IDLE, DONE).
- out_valid, result, zero and illegal come from registers. in_ready is decoded from state only, with no combinational input path.
- out_valid must not drop without out_ready; result must not change while out_valid=1.

## Test plan
- Reset mid-SHIFT: assert reset during an sll by 20 at cycle 5 → out_valid=0, result=0, zero=1, in_ready=1 in the same cycle. The next op (add 1+1) returns 2.
- Basic ops at XLEN=32, out_ready=1:
  - add 0x7FFFFFFF+1 → 0x80000000.
  - sub 5-5 → 0, zero=1.
  - xor 0xF0F0⊕0x0FF0 → 0xFF00.
  - Each has out_valid one cycle after accept.
- Compare: slt 0xFFFFFFFF,1 → 1; sltu 0xFFFFFFFF,1 → 0.
- Shifts:
  - sra 0x80000000 by 31 → 0xFFFFFFFF, out_valid exactly 31 cycles after the non-shift latency.
  - srl same operands → 0x00000001.
  - sll 1 by src_b=0x00000020 (amount 0) → 1 with non-shift latency.
- Backpressure: hold out_ready=0 for 10 cycles after an and-op result 0x0000000F → out_valid, result and zero stable, in_ready=0, in_valid pulses ignored. Release → IDLE next cycle.
- Illegal: alu_op=11, then alu_op=10 with {1,111} → illegal=1, result=0, zero=1. A following legal op clears illegal. Rerun the basic-ops and shift cases at XLEN=8: sra 0x80 by 7 → 0xFF.

Source files
------------

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - handshaked ALU with folded control decode and iterative one-bit-per-cycle shifter
module alu_seq_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
        OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_ILL
    } op_t;

    state_t          state;
    op_t             op;
    op_t             shift_op;
    logic [SHW-1:0]  cnt;
    logic [SHW-1:0]  shamt;
    logic            is_shift;
    logic [XLEN-1:0] alu_val;
    logic [XLEN-1:0] shift_val;

    assign shamt    = src_b[SHW-1:0];
    assign in_ready = (state == S_IDLE);
    assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

    // Fold the control-unit decode: alu_op selects add/sub directly, 10 defers to funct fields
    always_comb begin
        op = OP_ILL;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case ({funct7_5, funct3})
                    4'b0000: op = OP_ADD;
                    4'b1000: op = OP_SUB;
                    4'b0001: op = OP_SLL;
                    4'b0101: op = OP_SRL;
                    4'b1101: op = OP_SRA;
                    4'b0010: op = OP_SLT;
                    4'b0011: op = OP_SLTU;
                    4'b0100: op = OP_XOR;
                    4'b0110: op = OP_OR;
                    4'b0111: op = OP_AND;
                    default: op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    // Single-cycle result; shifts only reach here with amount 0, so they pass src_a through
    always_comb begin
        alu_val = '0;
        case (op)
            OP_ADD:  alu_val = src_a + src_b;
            OP_SUB:  alu_val = src_a - src_b;
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_val = src_a;
            OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  alu_val = src_a ^ src_b;
            OP_OR:   alu_val = src_a | src_b;
            OP_AND:  alu_val = src_a & src_b;
            default: alu_val = '0;
        endcase
    end

    // One-bit shift step applied to the result register while iterating
    always_comb begin
        shift_val = result;
        case (shift_op)
            OP_SLL:  shift_val = {result[XLEN-2:0], 1'b0};
            OP_SRL:  shift_val = {1'b0, result[XLEN-1:1]};
            default: shift_val = {result[XLEN-1], result[XLEN-1:1]};
        endcase
    end

    // Control FSM with registered outputs; reset drops any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= '0;
            shift_op  <= OP_SLL;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_shift && (shamt != '0)) begin
                            result   <= src_a;
                            cnt      <= shamt;
                            shift_op <= op;
                            illegal  <= 1'b0;
                            state    <= S_SHIFT;
                        end else begin
                            result    <= alu_val;
                            zero      <= (alu_val == '0);
                            illegal   <= (op == OP_ILL);
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    result <= shift_val;
                    cnt    <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        zero      <= (shift_val == '0);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
